systolic_feeder: RTL and testbench

- Upstream stage of systolic_top: buffers one tile of K reduction steps (A columns, B rows) over a valid/ready input and replays it into the array as diagonal wavefronts, row/column i delayed by i cycles.
- Drives the array's a_in, b_in and enable, plus an accumulator-clear pulse. Raises done once the last partial product has landed in the accumulators.

---
 rtl/systolic_pkg.sv | 9 +
 rtl/feeder_tile_buf.sv | 21 ++
 rtl/systolic_feeder.sv | 145 ++++++++++++++
 tb/tb_systolic_feeder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type, default geometry and drain length for the systolic slice
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} feeder_state_e;
  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 8;
  function automatic int DRAIN_CYCLES(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/feeder_tile_buf.sv
// feeder_tile_buf: MAX_K x ARRAY_SIZE operand store, one row write port, one read port per lane
module feeder_tile_buf import systolic_pkg::*; #(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_K = 16,
  parameter int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1
) (
  input  logic                                 clk,
  input  logic                                 we_i,
  input  logic [AW-1:0]                        waddr_i,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [ARRAY_SIZE-1:0][AW-1:0]         raddr_i,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] rdata_o
);
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] mem_q [MAX_K];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_rd
    assign rdata_o[i] = mem_q[raddr_i[i]][i];
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers a K-step tile and replays it as skewed wavefronts into the array.
// Define FEEDER_PERF_EN to get live perf_tiles/perf_stall counters (otherwise tied to 0).
module systolic_feeder import systolic_pkg::*; #(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_K = 16,
  parameter int K_WIDTH = $clog2(MAX_K + 1)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [K_WIDTH-1:0]                          k_len,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_vec,
  input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] b_vec,
  output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_out,
  output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] b_out,
  output logic                                        arr_enable,
  output logic                                        arr_clear,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        error,
  output logic [15:0]                                 perf_tiles,
  output logic [31:0]                                 perf_stall
);
  localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int CW = $clog2(MAX_K + 2 * ARRAY_SIZE);
  typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] vec_t;
  feeder_state_e state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d, wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, clr_q, clr_d, done_q, done_d, rdy_q, en_q, busy_q;
  vec_t a_q, a_d, b_q, b_d, a_rd, b_rd;
  logic [ARRAY_SIZE-1:0][AW-1:0] raddr;
  logic accept, k_ok;
  assign accept = state_q == LOAD && in_valid && rdy_q;
  assign k_ok = k_len != '0 && k_len <= K_WIDTH'(MAX_K);
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    wptr_d = wptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    clr_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        err_d = !k_ok;
        if (k_ok) begin
          state_d = LOAD;
          k_d = k_len;
          wptr_d = '0;
          clr_d = 1'b1;
        end
      end
      LOAD: if (accept) begin
        wptr_d = wptr_q + K_WIDTH'(1);
        if (wptr_q + K_WIDTH'(1) == k_q) begin
          state_d = STREAM;
          cnt_d = '0;
        end
      end
      STREAM: if (cnt_q + CW'(2) == CW'(k_q) + CW'(ARRAY_SIZE)) begin
        state_d = DRAIN;
        cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      DRAIN: if (cnt_q == CW'(DRAIN_CYCLES(ARRAY_SIZE) - 1)) begin
        state_d = IDLE;
        done_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  // Lanes look up the next cycle's operand; the beat landing this edge is forwarded (K=1 case).
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [CW-1:0] idx;
    logic on, fwd;
    assign idx = cnt_d - CW'(i);
    assign raddr[i] = idx[AW-1:0];
    assign on = state_d == STREAM && cnt_d >= CW'(i) && idx < CW'(k_q);
    assign fwd = accept && raddr[i] == wptr_q[AW-1:0];
    assign a_d[i] = !on ? '0 : fwd ? a_vec[i] : a_rd[i];
    assign b_d[i] = !on ? '0 : fwd ? b_vec[i] : b_rd[i];
  end
  feeder_tile_buf #(.ARRAY_SIZE(ARRAY_SIZE), .DATA_WIDTH(DATA_WIDTH), .MAX_K(MAX_K), .AW(AW)) u_abuf (
    .clk(clk), .we_i(accept), .waddr_i(wptr_q[AW-1:0]), .wdata_i(a_vec), .raddr_i(raddr), .rdata_o(a_rd)
  );
  feeder_tile_buf #(.ARRAY_SIZE(ARRAY_SIZE), .DATA_WIDTH(DATA_WIDTH), .MAX_K(MAX_K), .AW(AW)) u_bbuf (
    .clk(clk), .we_i(accept), .waddr_i(wptr_q[AW-1:0]), .wdata_i(b_vec), .raddr_i(raddr), .rdata_o(b_rd)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      k_q <= '0;
      wptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      clr_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      wptr_q <= wptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      clr_q <= clr_d;
      done_q <= done_d;
      rdy_q <= state_d == LOAD;
      en_q <= state_d == STREAM || state_d == DRAIN;
      busy_q <= state_d != IDLE;
      a_q <= a_d;
      b_q <= b_d;
    end
  assign in_ready = rdy_q;
  assign a_out = a_q;
  assign b_out = b_q;
  assign arr_enable = en_q;
  assign arr_clear = clr_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
`ifdef FEEDER_PERF_EN
  logic [15:0] tiles_q;
  logic [31:0] stall_q;
  always_ff @(posedge clk)
    if (!reset) begin
      tiles_q <= '0;
      stall_q <= '0;
    end else begin
      if (done_d && tiles_q != '1) tiles_q <= tiles_q + 16'd1;
      if (state_q == LOAD && !in_valid && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  assign perf_tiles = tiles_q;
  assign perf_stall = stall_q;
`else
  assign perf_tiles = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: random tiles checked against a wavefront model built from stored beats
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MK = 16;
  localparam int KW = 5;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [N-1:0][W-1:0] a_vec = '0;
  logic [N-1:0][W-1:0] b_vec = '0;
  logic [N-1:0][W-1:0] a_out, b_out;
  logic in_ready, arr_enable, arr_clear, busy, done, error;
  logic [15:0] perf_tiles;
  logic [31:0] perf_stall;
  int n_chk = 0;
  int n_err = 0;
  int tiles = 0;
  int stalls = 0;
  logic [W-1:0] ma [MK][N];
  logic [W-1:0] mb [MK][N];
  always #5 clk = ~clk;
  systolic_feeder dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .a_out(a_out), .b_out(b_out), .arr_enable(arr_enable),
    .arr_clear(arr_clear), .busy(busy), .done(done), .error(error),
    .perf_tiles(perf_tiles), .perf_stall(perf_stall)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Expected lane contents at stream cycle t: lane i carries beat t-i when that beat exists.
  function automatic logic [N*W-1:0] wave(input int t, input int k, input bit is_b);
    logic [N*W-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < k) v[i*W +: W] = is_b ? mb[t-i][i] : ma[t-i][i];
    return v;
  endfunction
  function automatic logic [W-1:0] opnd(input int mode, input int lane);
    return mode == 1 ? W'(lane + 1) : mode == 2 ? 8'h80 : W'($urandom);
  endfunction
  task automatic run_tile(input int k, input int amode, input int vmode, input int abort_t, input bit late_start);
    int beats = 0;
    int cyc = 0;
    bit v, seen;
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = KW'($urandom);
    chk("clear", arr_clear, 1);
    chk("error_clr", error, 0);
    chk("busy_load", busy, 1);
    while (beats < k && cyc < 400) begin
      chk("ready", in_ready, 1);
      chk("en_load", arr_enable, 0);
      if (cyc > 0) chk("clear_once", arr_clear, 0);
      v = vmode == 0 ? ($urandom_range(0, 2) != 0) : vmode == 1 ? (cyc % 2 == 0) : 1'b1;
      in_valid = v;
      for (int i = 0; i < N; i++) begin
        a_vec[i] = opnd(amode, i);
        b_vec[i] = opnd(amode, i);
      end
      if (v) begin
        for (int i = 0; i < N; i++) begin
          ma[beats][i] = a_vec[i];
          mb[beats][i] = b_vec[i];
        end
        beats++;
      end else stalls++;
      cyc++;
      @(negedge clk);
    end
    if (beats < k) chk("load_timeout", beats, k);
    for (int t = 0; t < k + N - 1; t++) begin
      in_valid = 1'(($urandom_range(0, 1)));
      a_vec = (N*W)'($urandom);
      b_vec = (N*W)'($urandom);
      chk("a_out", a_out, wave(t, k, 0));
      chk("b_out", b_out, wave(t, k, 1));
      chk("en_stream", arr_enable, 1);
      chk("ready_stream", in_ready, 0);
      chk("busy_stream", busy, 1);
      if (t == abort_t) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tiles = 0;
        stalls = 0;
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_en", arr_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        seen = 1'b0;
        repeat (40) begin
          @(negedge clk);
          if (done || arr_clear) seen = 1'b1;
        end
        chk("no_done_after_rst", seen, 0);
        return;
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2 * N - 1; d++) begin
      chk("a_drain", a_out, 0);
      chk("b_drain", b_out, 0);
      chk("en_drain", arr_enable, 1);
      chk("done_early", done, 0);
      start = late_start && d == 2;
      k_len = 5'd3;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("en_done", arr_enable, 0);
    tiles++;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle", busy, 0);
    chk("idle_ready", in_ready, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_arr_enable", arr_enable, 0);
    chk("rst_arr_clear", arr_clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    @(negedge clk);
    run_tile(1, 1, 2, -1, 0);
    run_tile(4, 0, 1, -1, 0);
    start = 1'b1;
    k_len = 5'd0;
    @(negedge clk);
    start = 1'b0;
    chk("err_zero", error, 1);
    chk("err_zero_busy", busy, 0);
    chk("err_zero_clear", arr_clear, 0);
    start = 1'b1;
    k_len = 5'd17;
    @(negedge clk);
    start = 1'b0;
    chk("err_big", error, 1);
    chk("err_big_busy", busy, 0);
    run_tile(2, 0, 0, -1, 0);
    run_tile(4, 0, 2, 2, 0);
    run_tile(3, 0, 0, -1, 1);
    run_tile(16, 2, 2, -1, 0);
    repeat (6) run_tile($urandom_range(1, 16), 0, 0, -1, 1'($urandom_range(0, 1)));
`ifdef FEEDER_PERF_EN
    chk("perf_tiles", perf_tiles, tiles);
    chk("perf_stall", perf_stall, stalls);
`else
    chk("perf_tiles", perf_tiles, 0);
    chk("perf_stall", perf_stall, 0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
